// File: rtl/div_hilo_ctrl_if.sv
// Bundles the HI/LO divide controller signals: CPU request side, divider core side and
// HI/LO register port. The controller uses the slave modport.
interface div_hilo_ctrl_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, op_a, op_b, div_q, div_r, hi_we, lo_we, wr_data,
        input  div_a, div_b, hi_out, lo_out, busy, done, div_by_zero
    );

    modport slave (
        input  start, op_a, op_b, div_q, div_r, hi_we, lo_we, wr_data,
        output div_a, div_b, hi_out, lo_out, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequences a signed divide through an external combinational divider core, waits a
// fixed settle time, then writes the quotient to LO and the sign-corrected remainder to HI.
module div_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic            clk,
    input logic            clr,
    div_hilo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_sign_a;
    logic [31:0] r_abs_b;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dbz;

    logic        w_accept;
    logic        w_op_b_zero;
    logic [31:0] w_rem_mag;
    logic [31:0] w_rem_fix;

    assign w_op_b_zero = (bus.op_b == '0);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = w_op_b_zero ? S_WRITE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Core remainder is a raw non-restoring value on magnitudes: restore once, then
    // give it the dividend's sign.
    always_comb begin
        w_rem_mag = bus.div_r[31] ? (bus.div_r + r_abs_b) : bus.div_r;
        w_rem_fix = r_sign_a ? (32'd0 - w_rem_mag) : w_rem_mag;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_abs_b  <= '0;
            r_div_a  <= '0;
            r_div_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_div_a  <= bus.op_a;
                r_div_b  <= bus.op_b;
                r_sign_a <= bus.op_a[31];
                r_abs_b  <= bus.op_b[31] ? (32'd0 - bus.op_b) : bus.op_b;
                if (!w_op_b_zero) begin
                    r_cnt <= 4'(SETTLE_CYCLES);
                end
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (bus.hi_we) begin
                r_hi <= bus.wr_data;
            end
            if (bus.lo_we) begin
                r_lo <= bus.wr_data;
            end

            // Later assignments override the direct HI/LO write in the result cycle.
            if (r_state == S_WRITE) begin
                r_done <= 1'b1;
                if (r_div_b == '0) begin
                    r_lo  <= '1;
                    r_hi  <= r_div_a;
                    r_dbz <= 1'b1;
                end else begin
                    r_lo  <= bus.div_q;
                    r_hi  <= w_rem_fix;
                    r_dbz <= 1'b0;
                end
            end
        end
    end

    assign bus.div_a       = r_div_a;
    assign bus.div_b       = r_div_b;
    assign bus.hi_out      = r_hi;
    assign bus.lo_out      = r_lo;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl: a transaction-level model of HI/LO, busy and done is
// checked every cycle, and each directed divide is also checked against literal values.
module tb_div_hilo_ctrl;
    localparam int SETTLE = 4;

    logic clk;
    logic clr;
    logic neg_form;
    int   n_checks;
    int   n_fail;
    logic chk_en;

    div_hilo_ctrl_if bus_if ();

    div_hilo_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_lo(input logic [31:0] a, input logic [31:0] b);
        if (b == '0) return '1;
        if (a == 32'h8000_0000 && b == '1) return 32'h8000_0000;
        return $signed(a) / $signed(b);
    endfunction

    function automatic logic [31:0] f_hi(input logic [31:0] a, input logic [31:0] b);
        if (b == '0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return $signed(a) % $signed(b);
    endfunction

    // Divider core stand-in; neg_form selects the unrestored (negative) remainder form.
    logic [31:0] c_abs_a, c_abs_b, c_mr;
    always_comb begin
        c_abs_a        = bus_if.div_a[31] ? (32'd0 - bus_if.div_a) : bus_if.div_a;
        c_abs_b        = bus_if.div_b[31] ? (32'd0 - bus_if.div_b) : bus_if.div_b;
        c_mr           = '0;
        bus_if.div_q   = '0;
        bus_if.div_r   = '0;
        if (bus_if.div_b != '0) begin
            c_mr         = c_abs_a % c_abs_b;
            bus_if.div_q = f_lo(bus_if.div_a, bus_if.div_b);
            bus_if.div_r = neg_form ? (c_mr - c_abs_b) : c_mr;
        end
    end

    // Reference model: a divide occupies a fixed number of cycles, then its result lands.
    int          m_left;
    logic [31:0] m_hi, m_lo, m_da, m_db, p_hi, p_lo;
    logic        m_done, m_dbz, p_dbz;

    always @(posedge clk) begin
        if (clr) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_da   <= '0;
            m_db   <= '0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_hi  <= p_hi;
                m_lo  <= p_lo;
                m_dbz <= p_dbz;
            end else begin
                if (bus_if.hi_we) m_hi <= bus_if.wr_data;
                if (bus_if.lo_we) m_lo <= bus_if.wr_data;
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
            end else if (bus_if.start) begin
                m_da   <= bus_if.op_a;
                m_db   <= bus_if.op_b;
                p_hi   <= f_hi(bus_if.op_a, bus_if.op_b);
                p_lo   <= f_lo(bus_if.op_a, bus_if.op_b);
                p_dbz  <= (bus_if.op_b == '0);
                m_left <= (bus_if.op_b == '0) ? 1 : SETTLE + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", {31'd0, bus_if.busy}, {31'd0, m_left != 0});
            chk("m_done", {31'd0, bus_if.done}, {31'd0, m_done});
            chk("m_dbz", {31'd0, bus_if.div_by_zero}, {31'd0, m_dbz});
            chk("m_hi", bus_if.hi_out, m_hi);
            chk("m_lo", bus_if.lo_out, m_lo);
            chk("m_div_a", bus_if.div_a, m_da);
            chk("m_div_b", bus_if.div_b, m_db);
        end
    end

    // Called on the falling edge right after the accepting edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus_if.busy ? 1 : 0;
        while (!bus_if.done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus_if.busy) bcnt++;
        end
        if (!bus_if.done) chk("done_timeout", {31'd0, bus_if.done}, 32'd1);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic neg,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edbz, input int elat);
        int lat, bcnt;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_a  = a;
        bus_if.op_b  = b;
        neg_form     = neg;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(lat, bcnt);
        chk("latency", lat, elat);
        chk("busy_cycles", bcnt, elat);
        chk("lo_lit", bus_if.lo_out, elo);
        chk("hi_lit", bus_if.hi_out, ehi);
        chk("dbz_lit", {31'd0, bus_if.div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        int lat, bcnt, dpulses;
        n_checks       = 0;
        n_fail         = 0;
        chk_en         = 1'b0;
        clr            = 1'b1;
        neg_form       = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.op_a    = '0;
        bus_if.op_b    = '0;
        bus_if.hi_we   = 1'b0;
        bus_if.lo_we   = 1'b0;
        bus_if.wr_data = '0;
        repeat (2) @(negedge clk);
        clr    = 1'b0;
        chk_en = 1'b1;
        chk("rst_hi", bus_if.hi_out, 32'd0);
        chk("rst_lo", bus_if.lo_out, 32'd0);
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst_done", {31'd0, bus_if.done}, 32'd0);

        do_div(32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 1'b0, 5);
        do_div(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 5);
        do_div(32'd7, -32'sd2, 1'b0, 32'hFFFF_FFFD, 32'd1, 1'b0, 5);
        do_div(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 5);
        do_div(32'd7, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1);
        do_div(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 5);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 5);
        do_div(-32'sd100, -32'sd7, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 5);
        do_div(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 5);
        do_div(32'd5, 32'd7, 1'b1, 32'd0, 32'd5, 1'b0, 5);
        do_div(32'h8000_0000, 32'd3, 1'b1, 32'hD555_5556, 32'hFFFF_FFFE, 1'b0, 5);

        // Second start while busy is dropped; a start in the done cycle is taken.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op_a = 32'd100; bus_if.op_b = 32'd7; neg_form = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op_a = 32'd50; bus_if.op_b = 32'd5;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_latency", lat, 32'd3);
        chk("ign_lo", bus_if.lo_out, 32'd14);
        chk("ign_hi", bus_if.hi_out, 32'd2);
        bus_if.start = 1'b1; bus_if.op_a = -32'sd20; bus_if.op_b = 32'd6; neg_form = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(lat, bcnt);
        chk("donecyc_latency", lat, 32'd5);
        chk("donecyc_lo", bus_if.lo_out, 32'hFFFF_FFFD);
        chk("donecyc_hi", bus_if.hi_out, 32'hFFFF_FFFE);

        // Clear on the second wait cycle abandons the divide.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op_a = 32'd7; bus_if.op_b = 32'd2; neg_form = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("clr_hi", bus_if.hi_out, 32'd0);
        chk("clr_lo", bus_if.lo_out, 32'd0);
        dpulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done) dpulses++;
        end
        chk("clr_no_done", dpulses, 32'd0);

        bus_if.hi_we = 1'b1; bus_if.wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        bus_if.hi_we = 1'b0;
        chk("mthi_hi", bus_if.hi_out, 32'hA5A5_A5A5);
        chk("mthi_lo", bus_if.lo_out, 32'd0);

        // Direct LO write held through a divide: the result still wins in its cycle.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op_a = 32'd9; bus_if.op_b = 32'd3; neg_form = 1'b0;
        bus_if.lo_we = 1'b1; bus_if.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("mtlo_wait_lo", bus_if.lo_out, 32'hDEAD_BEEF);
        wait_done(lat, bcnt);
        bus_if.lo_we = 1'b0;
        chk("mtlo_result_lo", bus_if.lo_out, 32'd3);
        chk("mtlo_result_hi", bus_if.hi_out, 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
